// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO for any depth >= 2,
// FWFT or registered read, level flags, flush and error pulses.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter bit FWFT       = 1'b1,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
    $error("sync_fifo_flex: illegal DEPTH or threshold");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, unf_q;
  logic                  wr_acc, rd_acc;

  // Explicit wrap so non-power-of-2 depths never index past the array.
  function automatic logic [ADDR_WIDTH-1:0] bump(
    input logic [ADDR_WIDTH-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_q == CNT_MAX);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = bump(wr_ptr_q);
      if (rd_acc) rd_ptr_d = bump(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= wr_en && full && !flush;
      unf_q    <= rd_en && empty && !flush;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (flush) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_q[rd_ptr_q];
      end
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed checks on a 16-deep FWFT FIFO
// and a 5-deep registered-read FIFO.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_din = 0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_count;

  logic       b_flush = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0] b_count;

  int n_pass = 0;
  int n_total = 0;

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .dout(a_dout),
    .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .wr_en(b_wr), .din(b_din), .rd_en(b_rd), .dout(b_dout),
    .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, both instances
    #2;
    check("rst_a_empty", a_empty, 1);
    check("rst_a_full", a_full, 0);
    check("rst_a_af", a_af, 0);
    check("rst_a_ae", a_ae, 1);
    check("rst_a_count", a_count, 0);
    check("rst_a_ovf", a_ovf, 0);
    check("rst_a_unf", a_unf, 0);
    check("rst_b_dout", b_dout, 0);
    check("rst_b_empty", b_empty, 1);
    tick;
    rst_n = 1;
    tick;

    // fill 0x01..0x10; almost_full from count 14
    for (int i = 1; i <= 16; i++) begin
      a_wr = 1; a_din = 8'(i);
      tick;
      check($sformatf("fill_cnt%0d", i), a_count, i);
      check($sformatf("fill_af%0d", i), a_af, (i >= 14) ? 1 : 0);
    end
    a_wr = 0;
    check("fill_full", a_full, 1);
    check("fill_ae", a_ae, 0);

    // full with wr+rd: read 0x01, drop 0xEE, overflow
    check("head_01", a_dout, 8'h01);
    a_wr = 1; a_rd = 1; a_din = 8'hEE;
    tick;
    a_wr = 0; a_rd = 0;
    check("ovf_pulse", a_ovf, 1);
    check("ovf_cnt", a_count, 15);
    check("ovf_full", a_full, 0);
    tick;
    check("ovf_clear", a_ovf, 0);

    // drain 0x02..0x10
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("drain_%0d", i), a_dout, i);
      a_rd = 1;
      tick;
    end
    a_rd = 0;
    check("drain_empty", a_empty, 1);
    check("drain_cnt", a_count, 0);
    check("drain_ovf", a_ovf, 0);

    // read on empty
    a_rd = 1;
    tick;
    a_rd = 0;
    check("unf_pulse", a_unf, 1);
    check("unf_cnt", a_count, 0);
    tick;
    check("unf_clear", a_unf, 0);

    // wr+rd on empty: write taken, read rejected
    a_wr = 1; a_rd = 1; a_din = 8'h5C;
    tick;
    a_wr = 0; a_rd = 0;
    check("we_cnt", a_count, 1);
    check("we_unf", a_unf, 1);
    check("we_dout", a_dout, 8'h5C);
    a_rd = 1;
    tick;
    a_rd = 0;
    check("we_drain", a_empty, 1);

    // flush at count 9 with a concurrent write
    for (int i = 0; i < 9; i++) begin
      a_wr = 1; a_din = 8'(8'h20 + i);
      tick;
    end
    a_wr = 0;
    check("pre_flush_cnt", a_count, 9);
    a_flush = 1; a_wr = 1; a_din = 8'h77;
    tick;
    a_flush = 0; a_wr = 0;
    check("flush_cnt", a_count, 0);
    check("flush_empty", a_empty, 1);
    check("flush_ae", a_ae, 1);
    check("flush_ovf", a_ovf, 0);
    check("flush_unf", a_unf, 0);
    a_wr = 1; a_din = 8'h33;
    tick;
    a_wr = 0;
    check("post_flush_dout", a_dout, 8'h33);
    check("post_flush_cnt", a_count, 1);

    // async reset mid-stream at count 7
    for (int i = 0; i < 6; i++) begin
      a_wr = 1; a_din = 8'(8'h60 + i);
      tick;
    end
    a_wr = 0;
    check("pre_rst_cnt", a_count, 7);
    rst_n = 0;
    #1;
    check("arst_cnt", a_count, 0);
    check("arst_empty", a_empty, 1);
    check("arst_full", a_full, 0);
    check("arst_af", a_af, 0);
    check("arst_ae", a_ae, 1);
    rst_n = 1;
    tick;
    a_wr = 1; a_din = 8'hA5;
    tick;
    a_wr = 0;
    check("a5_dout", a_dout, 8'hA5);
    check("a5_cnt", a_count, 1);
    a_rd = 1;
    tick;
    a_rd = 0;
    check("a5_empty", a_empty, 1);

    // depth 5, registered read: three fill/drain rounds
    check("b_dout_init", b_dout, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        b_wr = 1; b_din = 8'(8'h40 + r * 8 + i);
        tick;
        check($sformatf("b_af_r%0d_%0d", r, i), b_af,
              (i + 1 >= 3) ? 1 : 0);
      end
      b_wr = 0;
      check($sformatf("b_full_r%0d", r), b_full, 1);
      check($sformatf("b_cnt_r%0d", r), b_count, 5);
      for (int i = 0; i < 5; i++) begin
        b_rd = 1;
        tick;
        check($sformatf("b_rd_r%0d_%0d", r, i), b_dout,
              8'h40 + r * 8 + i);
      end
      b_rd = 0;
      check($sformatf("b_empty_r%0d", r), b_empty, 1);
      tick;
      check($sformatf("b_hold_r%0d", r), b_dout, 8'h40 + r * 8 + 4);
    end

    // flush clears registered dout
    b_wr = 1; b_din = 8'h9A;
    tick;
    b_wr = 0;
    b_flush = 1;
    tick;
    b_flush = 0;
    check("b_flush_dout", b_dout, 0);
    check("b_flush_cnt", b_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
